keygen_fsm_multi: RTL and testbench
===================================

Name: keygen_fsm_multi

Overview:
Parametrised successor to the AES-128 key-generation controller. It sequences word-serial key expansion for AES-128, AES-192 and AES-256, with the mode selected per run. It drives the key-schedule RAM, the SubWord/RotWord/Rcon datapath selects and a start/done handshake. It sits between the key input register and the round-key store that the cipher FSM reads.

Parameters:
SBOX_LAT, 1, SubWord pipeline latency in cycles (1..4).
ADDR_W, 6, key-schedule word address width (must hold 0..59).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  synchronous, active-low reset.
start  in  1  start request; sampled only in IDLE.
mode  in  2  key size: 00=128, 01=192, 10=256, 11=illegal.
key_rd_idx  out  3  input-key word index during LOAD (0..Nk-1).
ks_wr_en  out  1  key-schedule write strobe.
ks_wr_addr  out  ADDR_W  write word address.
ks_rd_addr_prev  out  ADDR_W  address of w[i-1].
ks_rd_addr_nk  out  ADDR_W  address of w[i-Nk].
sel_in  out  1  1 = write mux takes the input-key word; 0 = takes the expansion result.
rot_en  out  1  apply RotWord + Rcon to the current word.
sub_en  out  1  route the word through SubWord.
rcon_index  out  4  Rcon index, i/Nk.
busy  out  1  high from start acceptance until DONE exits.
done  out  1  one-cycle pulse when expansion completes.
err  out  1  one-cycle pulse when illegal mode is started.

Behaviour:
- Mode parameters: Nk = 4/6/8; total words T = 44/52/60. mode is latched on start acceptance; later changes are ignored until IDLE.
- Reset: while reset_n=0 at a clk edge, the FSM goes to IDLE and all outputs go to 0. This applies mid-run as well; partial schedule contents are undefined.
- IDLE: start=1 with legal mode -> LOAD with word i=0, busy=1 from the next cycle. start=1 with mode=11 -> err pulse on the next cycle, stay in IDLE, busy stays 0.
- LOAD: one word per cycle for Nk cycles. In each cycle key_rd_idx=i, sel_in=1, ks_wr_en=1, ks_wr_addr=i. After the word Nk-1 cycle, go to EXP with i=Nk.
- EXP: per word i, with ks_rd_addr_prev=i-1 and ks_rd_addr_nk=i-Nk.
  - i mod Nk == 0: rot_en=1, sub_en=1, rcon_index=i/Nk. Go to SUB_WAIT with no write this cycle.
  - Nk==8 and i mod 8 == 4: sub_en=1, rot_en=0. Go to SUB_WAIT.
  - Otherwise: ks_wr_en=1, ks_wr_addr=i, i++, in this same cycle.
- SUB_WAIT: hold addresses, rot_en, sub_en and rcon_index for SBOX_LAT cycles. On the last cycle assert ks_wr_en with ks_wr_addr=i, then i++ and return to EXP.
- Completion: the write of word T-1 moves the FSM to DONE. DONE asserts done=1 for one cycle, then busy=0 and the FSM returns to IDLE.
- start during busy is ignored; no queueing.
- Outputs not listed for a state are 0. All outputs are registered or decoded from the state register; no input-to-output combinational path.
- Substituted words per run: 128 -> 10, 192 -> 8, 256 -> 13.
- Start-to-done latency with start accepted at cycle 0: Nk + (T-Nk) + nsub*SBOX_LAT + 1.
  - SBOX_LAT=1: 128 -> 55, 192 -> 61, 256 -> 74.
- rcon_index range: 1..10 (128), 1..8 (192), 1..7 (256). The value is never 0 while rot_en=1.

Decomposition:
- Package aes_ks_pkg:
  - mode encoding constants;
  - Nk and T lookup functions;
  - state enum {IDLE, LOAD, EXP, SUB_WAIT, DONE}.
- Sub-module ks_word_cnt:
  - word index i;
  - a mod-Nk phase counter, so no divider is needed;
  - Rcon counter incremented at each phase wrap;
  - flags is_rot, is_sub256 and is_last.
- The FSM top instantiates one ks_word_cnt.

Test Plan:
- Reset, then start with mode=00, SBOX_LAT=1:
  - 4 LOAD writes to addresses 0..3;
  - ks_wr_en pulses total 44 with addresses 0..43, each exactly once and in order;
  - rot_en rising edges at i=4,8,..,40 with rcon_index 1..10;
  - done exactly 55 cycles after start.
- mode=01: 52 writes, rot at i=6,12,..,48 (rcon 1..8), done at cycle 61. Then mode=10:
  - rot at i=8,..,56 with rcon 1..7;
  - sub-only at i=12,20,..,52;
  - done at cycle 74.
- SBOX_LAT=3, mode=00: each rot word holds in SUB_WAIT for 3 cycles with stable addresses; done at cycle 75.
- start pulses in mid-run with mode=10: no effect, sequence identical to a clean mode-00 run. mode=11 start in IDLE: single err pulse, busy stays 0, no writes.
- reset_n=0 for 1 cycle during EXP at i=20: all outputs 0 the next cycle. A new start (mode=00) then runs a full, correct 55-cycle sequence.

Source files
------------

// File: rtl/aes_ks_pkg.sv
// rtl/aes_ks_pkg.sv - shared types and lookups for the AES key-expansion controller
// Purpose: mode encodings, controller state type, and Nk / total-word lookups
//          for AES-128, AES-192 and AES-256 key schedules.
// Ports:   none (package).
package aes_ks_pkg;

  localparam logic [1:0] MODE_128     = 2'b00;
  localparam logic [1:0] MODE_192     = 2'b01;
  localparam logic [1:0] MODE_256     = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXP,
    SUB_WAIT,
    DONE
  } ks_state_t;

  // Input-key length in 32-bit words.
  function automatic logic [3:0] nk_of(input logic [1:0] m);
    case (m)
      MODE_192: return 4'd6;
      MODE_256: return 4'd8;
      default:  return 4'd4;
    endcase
  endfunction

  // Total expanded schedule length in words.
  function automatic logic [5:0] total_of(input logic [1:0] m);
    case (m)
      MODE_192: return 6'd52;
      MODE_256: return 6'd60;
      default:  return 6'd44;
    endcase
  endfunction

endpackage

// File: rtl/ks_word_cnt.sv
// rtl/ks_word_cnt.sv - word index, mod-Nk phase and Rcon counters for key expansion
// Purpose: tracks schedule word index i, its phase i mod Nk and i/Nk without a divider.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   clear             return all counters to word 0
//   adv               a word was written this cycle; step to the next one
//   mode              latched key-size mode (selects Nk and total length)
//   word_idx          current word index i
//   rcon              i/Nk (Rcon index)
//   is_rot            i mod Nk == 0
//   is_sub256         AES-256 mid-group SubWord-only word (i mod 8 == 4)
//   is_last           i is the final schedule word
//   group_end         i mod Nk == Nk-1
module ks_word_cnt
  import aes_ks_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              adv,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] word_idx,
  output logic [3:0]        rcon,
  output logic              is_rot,
  output logic              is_sub256,
  output logic              is_last,
  output logic              group_end
);

  logic [2:0] phase;
  logic [3:0] nk;

  assign nk        = nk_of(mode);
  assign group_end = ({1'b0, phase} == (nk - 4'd1));
  assign is_rot    = (phase == 3'd0);
  assign is_sub256 = (nk == 4'd8) && (phase == 3'd4);
  assign is_last   = (word_idx == ADDR_W'(total_of(mode) - 6'd1));

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      word_idx <= '0;
      phase    <= 3'd0;
      rcon     <= 4'd0;
    end else if (adv) begin
      word_idx <= word_idx + ADDR_W'(1);
      // rcon tracks i/Nk by stepping whenever the phase wraps.
      if (group_end) begin
        phase <= 3'd0;
        rcon  <= rcon + 4'd1;
      end else begin
        phase <= phase + 3'd1;
      end
    end
  end

endmodule

// File: rtl/keygen_fsm_multi.sv
// rtl/keygen_fsm_multi.sv - AES-128/192/256 word-serial key-expansion controller
// Purpose: sequences loading of the input key and word-serial expansion into the
//          key-schedule RAM, driving the SubWord/RotWord/Rcon selects.
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   start, mode        run request and key size (sampled in IDLE only)
//   key_rd_idx         input-key word index during LOAD
//   ks_wr_en/addr      key-schedule write strobe and word address
//   ks_rd_addr_prev    address of w[i-1]
//   ks_rd_addr_nk      address of w[i-Nk]
//   sel_in             write mux takes the input-key word
//   rot_en, sub_en     RotWord+Rcon and SubWord selects
//   rcon_index         i/Nk while rot_en is high
//   busy, done, err    run status, completion pulse, illegal-mode pulse
module keygen_fsm_multi
  import aes_ks_pkg::*;
#(
  parameter int SBOX_LAT = 1,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [2:0]        key_rd_idx,
  output logic              ks_wr_en,
  output logic [ADDR_W-1:0] ks_wr_addr,
  output logic [ADDR_W-1:0] ks_rd_addr_prev,
  output logic [ADDR_W-1:0] ks_rd_addr_nk,
  output logic              sel_in,
  output logic              rot_en,
  output logic              sub_en,
  output logic [3:0]        rcon_index,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] WAIT_LAST = 2'(SBOX_LAT - 1);

  ks_state_t         state;
  logic [1:0]        mode_q;
  logic [1:0]        wait_cnt;
  logic              err_q;

  logic [ADDR_W-1:0] word_idx;
  logic [3:0]        rcon;
  logic              is_rot;
  logic              is_sub256;
  logic              is_last;
  logic              group_end;
  logic              cnt_clear;
  logic              expanding;
  logic              sub_word;
  logic              wr;

  assign cnt_clear = (state == IDLE);
  assign expanding = (state == EXP) || (state == SUB_WAIT);
  assign sub_word  = is_rot || is_sub256;
  // A SubWord word is written only on the final SUB_WAIT cycle; others write in EXP.
  assign wr = (state == LOAD)
           || ((state == EXP) && !sub_word)
           || ((state == SUB_WAIT) && (wait_cnt == WAIT_LAST));

  ks_word_cnt #(
    .ADDR_W(ADDR_W)
  ) u_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (cnt_clear),
    .adv       (wr),
    .mode      (mode_q),
    .word_idx  (word_idx),
    .rcon      (rcon),
    .is_rot    (is_rot),
    .is_sub256 (is_sub256),
    .is_last   (is_last),
    .group_end (group_end)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      mode_q   <= MODE_128;
      wait_cnt <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (mode == MODE_ILLEGAL) begin
              err_q <= 1'b1;
            end else begin
              mode_q <= mode;
              state  <= LOAD;
            end
          end
        end
        LOAD: begin
          if (group_end) state <= EXP;
        end
        EXP: begin
          if (sub_word) begin
            wait_cnt <= 2'd0;
            state    <= SUB_WAIT;
          end else if (is_last) begin
            state <= DONE;
          end
        end
        SUB_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= is_last ? DONE : EXP;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign err             = err_q;
  assign sel_in          = (state == LOAD);
  assign key_rd_idx      = (state == LOAD) ? word_idx[2:0] : 3'd0;
  assign ks_wr_en        = wr;
  assign ks_wr_addr      = wr ? word_idx : '0;
  assign ks_rd_addr_prev = expanding ? (word_idx - ADDR_W'(1)) : '0;
  assign ks_rd_addr_nk   = expanding ? (word_idx - ADDR_W'(nk_of(mode_q))) : '0;
  assign rot_en          = expanding && is_rot;
  assign sub_en          = expanding && sub_word;
  assign rcon_index      = (expanding && is_rot) ? rcon : 4'd0;

endmodule

// File: tb/tb_keygen_fsm_multi.sv
// tb/tb_keygen_fsm_multi.sv - directed self-checking bench for keygen_fsm_multi
module tb_keygen_fsm_multi;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start1 = 1'b0;
  logic [1:0] mode1 = 2'b00;
  logic       start3 = 1'b0;
  logic [1:0] mode3 = 2'b00;

  int checks = 0;
  int failures = 0;

  logic [2:0] a_kidx, b_kidx;
  logic       a_wen, b_wen;
  logic [5:0] a_waddr, b_waddr, a_prev, b_prev, a_nk, b_nk;
  logic       a_sel, b_sel, a_rot, b_rot, a_sub, b_sub;
  logic [3:0] a_rcon, b_rcon;
  logic       a_busy, b_busy, a_done, b_done, a_err, b_err;

  logic [31:0] ob1, ob3;
  assign ob1 = {a_kidx, a_wen, a_waddr, a_prev, a_nk, a_sel, a_rot, a_sub, a_rcon, a_busy, a_done, a_err};
  assign ob3 = {b_kidx, b_wen, b_waddr, b_prev, b_nk, b_sel, b_rot, b_sub, b_rcon, b_busy, b_done, b_err};

  always #5 clk = ~clk;

  keygen_fsm_multi #(.SBOX_LAT(1), .ADDR_W(6)) dut1 (
    .clk(clk), .reset_n(rstn), .start(start1), .mode(mode1),
    .key_rd_idx(a_kidx), .ks_wr_en(a_wen), .ks_wr_addr(a_waddr),
    .ks_rd_addr_prev(a_prev), .ks_rd_addr_nk(a_nk), .sel_in(a_sel),
    .rot_en(a_rot), .sub_en(a_sub), .rcon_index(a_rcon),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  keygen_fsm_multi #(.SBOX_LAT(3), .ADDR_W(6)) dut3 (
    .clk(clk), .reset_n(rstn), .start(start3), .mode(mode3),
    .key_rd_idx(b_kidx), .ks_wr_en(b_wen), .ks_wr_addr(b_waddr),
    .ks_rd_addr_prev(b_prev), .ks_rd_addr_nk(b_nk), .sel_in(b_sel),
    .rot_en(b_rot), .sub_en(b_sub), .rcon_index(b_rcon),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive_start(input bit u3, input logic v, input logic [1:0] m);
    if (u3) begin
      start3 = v;
      mode3  = m;
    end else begin
      start1 = v;
      mode1  = m;
    end
  endtask

  // Runs one expansion from IDLE, entered at a negedge, and tallies the
  // observed write/rot/sub/done behaviour against hand-computed totals.
  task automatic run(input string tag, input bit u3, input logic [1:0] m,
                     input int exp_w, input int exp_nk, input int exp_rot,
                     input int exp_subo, input int exp_done, input int exp_hold,
                     input bit noise);
    int wr_n = 0, wr_bad = 0, load_n = 0, load_bad = 0;
    int rot_n = 0, rot_bad = 0, hold_bad = 0, hold_len = 0;
    int subo_n = 0, subo_bad = 0, done_cyc = -1, busy_bad = 0, err_n = 0;
    int hold_prev = 0, hold_nk = 0, i = 0;
    logic prev_rot = 1'b0, prev_subo = 1'b0, subo;
    logic [31:0] ob;
    drive_start(u3, 1'b1, m);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) drive_start(u3, 1'b0, m);
      if (noise && (k == 10 || k == 33)) drive_start(u3, 1'b1, 2'b10);
      if (noise && (k == 11 || k == 34)) drive_start(u3, 1'b0, 2'b10);
      ob = u3 ? ob3 : ob1;
      if (!ob[2]) busy_bad++;
      if (ob[0]) err_n++;
      if (ob[28]) begin
        if (int'(ob[27:22]) != wr_n) wr_bad++;
        if (ob[9]) begin
          load_n++;
          if (int'(ob[31:29]) != wr_n || wr_n >= exp_nk) load_bad++;
        end else if (wr_n < exp_nk) begin
          load_bad++;
        end
        wr_n++;
      end
      i = int'(ob[21:16]) + 1;
      if (ob[8] && !prev_rot) begin
        if (i != (rot_n + 1) * exp_nk || int'(ob[6:3]) != rot_n + 1 || !ob[7]
            || int'(ob[15:10]) != i - exp_nk) rot_bad++;
        rot_n++;
        hold_len  = 1;
        hold_prev = int'(ob[21:16]);
        hold_nk   = int'(ob[15:10]);
      end else if (ob[8]) begin
        hold_len++;
        if (int'(ob[21:16]) != hold_prev || int'(ob[15:10]) != hold_nk) hold_bad++;
      end
      if (!ob[8] && prev_rot && hold_len != exp_hold) hold_bad++;
      subo = ob[7] && !ob[8];
      if (subo && !prev_subo) begin
        if (i != 12 + 8 * subo_n) subo_bad++;
        subo_n++;
      end
      prev_rot  = ob[8];
      prev_subo = subo;
      if (ob[1]) begin
        done_cyc = k;
        break;
      end
    end
    check_eq({tag, "_writes"}, wr_n, exp_w);
    check_eq({tag, "_wr_order"}, wr_bad, 0);
    check_eq({tag, "_load_writes"}, load_n, exp_nk);
    check_eq({tag, "_load_bad"}, load_bad, 0);
    check_eq({tag, "_rot_count"}, rot_n, exp_rot);
    check_eq({tag, "_rot_bad"}, rot_bad, 0);
    check_eq({tag, "_hold_bad"}, hold_bad, 0);
    check_eq({tag, "_subonly_count"}, subo_n, exp_subo);
    check_eq({tag, "_subonly_bad"}, subo_bad, 0);
    check_eq({tag, "_done_cycle"}, done_cyc, exp_done);
    check_eq({tag, "_busy_gap"}, busy_bad, 0);
    check_eq({tag, "_err_seen"}, err_n, 0);
    @(negedge clk);
    ob = u3 ? ob3 : ob1;
    check_eq({tag, "_after_done_busy_done"}, {30'd0, ob[2], ob[1]}, 0);
  endtask

  task automatic illegal_start();
    int wr_n = 0, err_n = 0, busy_n = 0;
    drive_start(1'b0, 1'b1, 2'b11);
    @(negedge clk);
    drive_start(1'b0, 1'b0, 2'b00);
    check_eq("illegal_err_pulse", ob1[0], 1);
    check_eq("illegal_busy", ob1[2], 0);
    check_eq("illegal_wr_en", ob1[28], 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ob1[28]) wr_n++;
      if (ob1[0]) err_n++;
      if (ob1[2]) busy_n++;
    end
    check_eq("illegal_later_writes", wr_n, 0);
    check_eq("illegal_later_err", err_n, 0);
    check_eq("illegal_later_busy", busy_n, 0);
  endtask

  task automatic mid_reset();
    bit found = 0;
    drive_start(1'b0, 1'b1, 2'b00);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) drive_start(1'b0, 1'b0, 2'b00);
      if (ob1[8] && ob1[21:16] == 6'd19) begin
        found = 1;
        break;
      end
    end
    check_eq("midrst_reached_i20", found, 1);
    rstn = 1'b0;
    @(negedge clk);
    check_eq("midrst_outputs_zero", ob1, 0);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("midrst_stays_idle", ob1, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_outputs_lat1", ob1, 0);
    check_eq("reset_outputs_lat3", ob3, 0);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("idle_outputs_lat1", ob1, 0);

    run("m128",      1'b0, 2'b00, 44, 4, 10, 0, 55, 2, 1'b0);
    run("m192",      1'b0, 2'b01, 52, 6,  8, 0, 61, 2, 1'b0);
    run("m256",      1'b0, 2'b10, 60, 8,  7, 6, 74, 2, 1'b0);
    run("m128_lat3", 1'b1, 2'b00, 44, 4, 10, 0, 75, 4, 1'b0);
    run("m128_noise",1'b0, 2'b00, 44, 4, 10, 0, 55, 2, 1'b1);
    illegal_start();
    mid_reset();
    run("m128_post_reset", 1'b0, 2'b00, 44, 4, 10, 0, 55, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
